fx_pt_add_arb: RTL

//   Shares one fx_pt_add_rnd instance between two requesters (0 and 1) with valid/ready handshakes.

---
 rtl/fx_pt_add_arb_if.sv | 40 ++++
 rtl/fx_pt_add_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fx_pt_add_arb_if.sv
// Handshake bundle between two operand requesters, the shared rounding adder
// arbiter, and the result consumer.
interface fx_pt_add_arb_if #(
  parameter int AIW = 2,
  parameter int AFW = 5,
  parameter int BIW = 4,
  parameter int BFW = 6,
  parameter int SIW = (AIW > BIW) ? AIW + 2 : BIW + 2,
  parameter int SFW = 3
);
  logic                 req0_valid;
  logic [AIW+AFW-1:0]   req0_a;
  logic [BIW+BFW-1:0]   req0_b;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [AIW+AFW-1:0]   req1_a;
  logic [BIW+BFW-1:0]   req1_b;
  logic                 req1_ready;
  logic                 res_valid;
  logic [SIW+SFW-1:0]   res_sum;
  logic                 res_id;
  logic                 res_ready;
  logic                 idle;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_id, idle
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_id, idle
  );
endinterface

// File: rtl/fx_pt_add_arb.sv
// Two-requester arbiter in front of one shared fixed-point rounding adder, with a
// 2-stage pipeline. Define FX_PT_ADD_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins).
module fx_pt_add_arb #(
  parameter int SN  = 0,
  parameter int AIW = 2,
  parameter int AFW = 5,
  parameter int BIW = 4,
  parameter int BFW = 6,
  parameter int SIW = (AIW > BIW) ? AIW + 2 : BIW + 2,
  parameter int SFW = 3
) (
  input  logic               clk,
  input  logic               rst,
  fx_pt_add_arb_if.slave     bus
);
  localparam int AW = AIW + AFW;
  localparam int BW = BIW + BFW;
  localparam int SW = SIW + SFW;
  localparam int FW = (AFW > BFW) ? AFW : BFW;
  localparam int WW = SIW + FW;

  logic          v1_q, v1_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [BW-1:0] b1_q, b1_d;
  logic          id1_q, id1_d;
  logic          v2_q, v2_d;
  logic [SW-1:0] sum2_q, sum2_d;
  logic          id2_q, id2_d;

  logic          adv1_s, adv2_s;
  logic          gnt_vld_s, gnt_id_s, acc_s;
  logic          sx_a_s, sx_b_s;
  logic [WW-1:0] a_al_s, b_al_s, full_s;
  logic [SW-1:0] sum_s;

`ifndef FX_PT_ADD_ARB_FIXED_PRI_EN
  logic          ptr_q, ptr_d;
`endif

  // Pipeline advance and arbitration; nothing is granted while reset is held.
  always_comb begin
    adv2_s    = !v2_q | bus.res_ready;
    adv1_s    = !v1_q | adv2_s;
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b0;
      end
      2'b10: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b1;
      end
      2'b11: begin
        gnt_vld_s = 1'b1;
`ifdef FX_PT_ADD_ARB_FIXED_PRI_EN
        gnt_id_s  = 1'b0;
`else
        gnt_id_s  = ptr_q;
`endif
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    endcase
    acc_s = adv1_s & gnt_vld_s & !rst;
  end

  assign bus.req0_ready = acc_s & !gnt_id_s;
  assign bus.req1_ready = acc_s &  gnt_id_s;
  assign bus.res_valid  = v2_q;
  assign bus.res_sum    = sum2_q;
  assign bus.res_id     = id2_q;
  assign bus.idle       = !v1_q & !v2_q;

  // Align both operands to a common binary point and add at full precision.
  always_comb begin
    sx_a_s = (SN != 0) ? a1_q[AW-1] : 1'b0;
    sx_b_s = (SN != 0) ? b1_q[BW-1] : 1'b0;
    a_al_s = {{(WW-AW){sx_a_s}}, a1_q} << (FW - AFW);
    b_al_s = {{(WW-BW){sx_b_s}}, b1_q} << (FW - BFW);
    full_s = a_al_s + b_al_s;
  end

  // Round half-up to SFW fraction bits: add half an output LSB, then drop the low bits.
  generate
    if (FW > SFW) begin : g_rnd
      localparam int SH = FW - SFW;
      logic [WW-1:0] rnd_s;
      always_comb begin
        rnd_s = full_s + ({{(WW-1){1'b0}}, 1'b1} << (SH - 1));
        sum_s = rnd_s[WW-1:SH];
      end
    end else if (FW == SFW) begin : g_eq
      always_comb begin
        sum_s = full_s;
      end
    end else begin : g_pad
      always_comb begin
        sum_s = {full_s, {(SFW-FW){1'b0}}};
      end
    end
  endgenerate

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    id1_d  = id1_q;
    v2_d   = v2_q;
    sum2_d = sum2_q;
    id2_d  = id2_q;
`ifndef FX_PT_ADD_ARB_FIXED_PRI_EN
    ptr_d  = acc_s ? ~gnt_id_s : ptr_q;
`endif
    if (adv1_s) begin
      v1_d = acc_s;
      if (acc_s) begin
        a1_d  = gnt_id_s ? bus.req1_a : bus.req0_a;
        b1_d  = gnt_id_s ? bus.req1_b : bus.req0_b;
        id1_d = gnt_id_s;
      end else begin
        id1_d = id1_q;
      end
    end else begin
      v1_d = v1_q;
    end
    if (adv2_s) begin
      v2_d   = v1_q;
      sum2_d = sum_s;
      id2_d  = id1_q;
    end else begin
      v2_d   = v2_q;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= {AW{1'b0}};
      b1_q   <= {BW{1'b0}};
      id1_q  <= 1'b0;
      v2_q   <= 1'b0;
      sum2_q <= {SW{1'b0}};
      id2_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      id1_q  <= id1_d;
      v2_q   <= v2_d;
      sum2_q <= sum2_d;
      id2_q  <= id2_d;
    end
  end

`ifndef FX_PT_ADD_ARB_FIXED_PRI_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif
endmodule
